// File: rtl/gemm_pkg.sv
// Shared GEMM definitions: default result tile geometry, the result-writer
// state encoding and a small sizing helper for counters and pointers.
package gemm_pkg;

  // Default result tile geometry (rows x columns of accumulator results).
  localparam int TileM = 4;
  localparam int TileN = 16;

  // Result writer control states.
  typedef enum logic [1:0] {
    WriterIdle   = 2'd0,
    WriterActive = 2'd1,
    WriterDone   = 2'd2
  } writer_state_e;

  // Bits needed to index 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gemm_tile_fifo.sv
// Small circular buffer holding whole result tiles. The head entry is
// visible combinationally so the writer can slice rows out of it in the
// same cycle it issues them; a push into a full buffer is accepted only
// when a pop frees the head slot in that same cycle.
module gemm_tile_fifo #(
  parameter int Width = 32,
  parameter int Depth = 2,
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [Width-1:0]  data_i,
  output logic [Width-1:0]  data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CntW-1:0]   count_o
);
  import gemm_pkg::*;

  localparam int PtrW = cnt_width(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy update; flush discards everything buffered.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tile storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/gemm_result_writer.sv
// Drains buffered GEMM result tiles into the output SRAM one tile row per
// cycle, walking tiles n-fastest then m, and addressing C row-major with one
// SRAM word per TileN columns.
module gemm_result_writer #(
  parameter int AddrWidth = 16,
  parameter int DataWidth = 32,
  parameter int TileM     = gemm_pkg::TileM,
  parameter int TileN     = gemm_pkg::TileN,
  parameter int FifoDepth = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [AddrWidth-1:0]             M_size_i,
  input  logic [AddrWidth-1:0]             N_size_i,
  input  logic                             result_valid_i,
  input  logic [TileM*TileN*DataWidth-1:0] result_data_i,
  output logic                             stall_o,
  output logic                             wr_en_o,
  output logic [AddrWidth-1:0]             wr_addr_o,
  output logic [TileN*DataWidth-1:0]       wr_data_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             overflow_o
);
  import gemm_pkg::*;

  localparam int RowW     = TileN * DataWidth;
  localparam int TileW    = TileM * RowW;
  localparam int RowCntW  = cnt_width(TileM);
  localparam int FifoCntW = $clog2(FifoDepth + 1);

  writer_state_e          state_q, state_d;
  logic [AddrWidth-1:0]   m_tiles_q, m_tiles_d;
  logic [AddrWidth-1:0]   n_tiles_q, n_tiles_d;
  logic [AddrWidth-1:0]   m_tile_q, m_tile_d;
  logic [AddrWidth-1:0]   n_tile_q, n_tile_d;
  logic [RowCntW-1:0]     row_q, row_d;
  logic                   fin_q, fin_d;
  logic                   overflow_q, overflow_d;
  logic                   wr_en_q, wr_en_d;
  logic [AddrWidth-1:0]   wr_addr_q, wr_addr_d;
  logic [RowW-1:0]        wr_data_q, wr_data_d;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_flush;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FifoCntW-1:0]    fifo_count;
  logic [TileW-1:0]       head_tile;
  logic [RowW-1:0]        head_rows [TileM];

  logic                   active;
  logic                   issue;
  logic                   last_row;
  logic                   drop;
  logic [AddrWidth-1:0]   row_addr;
  logic [AddrWidth-1:0]   issue_addr;

  gemm_tile_fifo #(
    .Width (TileW),
    .Depth (FifoDepth)
  ) u_tile_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (result_data_i),
    .data_o  (head_tile),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Split the head tile into its rows; row r starts at element r*TileN.
  for (genvar gi = 0; gi < TileM; gi++) begin : g_rows
    assign head_rows[gi] = head_tile[gi*RowW +: RowW];
  end

  // Once the final row is issued (fin_q) nothing more is written; the
  // extra Active cycle lets done_o follow the last write strobe.
  assign active     = (state_q == WriterActive);
  assign issue      = active && !fin_q && !fifo_empty;
  assign last_row   = (row_q == RowCntW'(TileM - 1));
  assign fifo_pop   = issue && last_row;
  assign fifo_push  = active && result_valid_i && (!fifo_full || fifo_pop);
  assign drop       = active && result_valid_i && fifo_full && !fifo_pop;
  assign fifo_flush = (state_q == WriterDone);

  // Word address of the row being issued, wrapping at 2^AddrWidth.
  assign row_addr   = m_tile_q * AddrWidth'(TileM) + AddrWidth'(row_q);
  assign issue_addr = row_addr * n_tiles_q + n_tile_q;

  // Job control, tile/row walk and next write-port values.
  always_comb begin
    state_d    = state_q;
    m_tiles_d  = m_tiles_q;
    n_tiles_d  = n_tiles_q;
    m_tile_d   = m_tile_q;
    n_tile_d   = n_tile_q;
    row_d      = row_q;
    fin_d      = fin_q;
    overflow_d = overflow_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      WriterIdle: begin
        if (start_i) begin
          m_tiles_d  = M_size_i / AddrWidth'(TileM);
          n_tiles_d  = N_size_i / AddrWidth'(TileN);
          m_tile_d   = '0;
          n_tile_d   = '0;
          row_d      = '0;
          fin_d      = 1'b0;
          overflow_d = 1'b0;
          if ((m_tiles_d == '0) || (n_tiles_d == '0)) begin
            state_d = WriterDone;
          end else begin
            state_d = WriterActive;
          end
        end
      end

      WriterActive: begin
        if (drop) begin
          overflow_d = 1'b1;
        end
        if (fin_q) begin
          state_d = WriterDone;
        end else if (issue) begin
          wr_en_d   = 1'b1;
          wr_addr_d = issue_addr;
          wr_data_d = head_rows[row_q];
          if (last_row) begin
            row_d = '0;
            if (n_tile_q == n_tiles_q - 1'b1) begin
              n_tile_d = '0;
              if (m_tile_q == m_tiles_q - 1'b1) begin
                fin_d = 1'b1;
              end else begin
                m_tile_d = m_tile_q + 1'b1;
              end
            end else begin
              n_tile_d = n_tile_q + 1'b1;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end

      WriterDone: begin
        state_d = WriterIdle;
      end

      default: begin
        state_d = WriterIdle;
      end
    endcase
  end

  // State, counters and registered write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= WriterIdle;
      m_tiles_q  <= '0;
      n_tiles_q  <= '0;
      m_tile_q   <= '0;
      n_tile_q   <= '0;
      row_q      <= '0;
      fin_q      <= 1'b0;
      overflow_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      m_tiles_q  <= m_tiles_d;
      n_tiles_q  <= n_tiles_d;
      m_tile_q   <= m_tile_d;
      n_tile_q   <= n_tile_d;
      row_q      <= row_d;
      fin_q      <= fin_d;
      overflow_q <= overflow_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign stall_o    = (fifo_count == FifoCntW'(FifoDepth));
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = (state_q != WriterIdle);
  assign done_o     = (state_q == WriterDone);
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_gemm_result_writer.sv
// Directed bench for gemm_result_writer: expected write sequences come from
// a table of {address, tile id, row} records; multi-cycle corner cases
// (stall, overflow, empty job, mid-job reset) are hand-written sequences.
module tb_gemm_result_writer;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TM = 4;
  localparam int TN = 16;
  localparam int FD = 2;
  localparam int RW = TN * DW;
  localparam int TW = TM * RW;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] M_size_i = '0;
  logic [AW-1:0] N_size_i = '0;
  logic          result_valid_i = 1'b0;
  logic [TW-1:0] result_data_i = '0;
  logic          stall_o;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [RW-1:0] wr_data_o;
  logic          busy_o;
  logic          done_o;
  logic          overflow_o;

  gemm_result_writer #(
    .AddrWidth (AW),
    .DataWidth (DW),
    .TileM     (TM),
    .TileN     (TN),
    .FifoDepth (FD)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .M_size_i       (M_size_i),
    .N_size_i       (N_size_i),
    .result_valid_i (result_valid_i),
    .result_data_i  (result_data_i),
    .stall_o        (stall_o),
    .wr_en_o        (wr_en_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/done/stall monitor, sampled on the falling edge.
  logic [AW-1:0] w_addr [$];
  logic [RW-1:0] w_data [$];
  int            w_cyc [$];
  int            stall_cnt = 0;
  int            done_cnt = 0;
  always @(negedge clk) begin
    if (wr_en_o) begin
      w_addr.push_back(wr_addr_o);
      w_data.push_back(wr_data_o);
      w_cyc.push_back(cyc);
    end
    if (stall_o) stall_cnt <= stall_cnt + 1;
    if (done_o) done_cnt <= done_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    int            tile;
    int            row;
  } vec_t;
  vec_t tbl [56];

  function automatic logic [RW-1:0] make_row(input int id, input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int c = 0; c < TN; c++) v[c*DW +: DW] = DW'((id << 16) | (r << 8) | c);
    return v;
  endfunction

  function automatic logic [TW-1:0] make_tile(input int id);
    logic [TW-1:0] v;
    for (int r = 0; r < TM; r++) v[r*RW +: RW] = make_row(id, r);
    return v;
  endfunction

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int m, input int n);
    M_size_i = AW'(m);
    N_size_i = AW'(n);
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
  endtask

  task automatic push(input int id);
    result_valid_i = 1'b1;
    result_data_i  = make_tile(id);
    tick();
    result_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int dc);
    int n;
    dc = -1;
    n  = 0;
    while (dc < 0 && n < maxc) begin
      if (done_o) dc = cyc;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic wait_no_stall(input int maxc);
    int n;
    n = 0;
    while (stall_o && n < maxc) begin
      tick();
      n++;
    end
    chk("stall_release", stall_o, 1'b0);
  endtask

  // Compare captured writes from index base against table rows first..first+n-1;
  // t0 is the cycle of the first write, later writes must follow with no gap.
  task automatic verify_tbl(input string tag, input int base, input int first,
                            input int n, input int t0);
    chk({tag, "_count"}, w_addr.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < w_addr.size()) begin
        chk({tag, "_addr"}, w_addr[base+i], tbl[first+i].addr);
        chk({tag, "_data"}, w_data[base+i], make_row(tbl[first+i].tile, tbl[first+i].row));
        chk({tag, "_cycle"}, w_cyc[base+i], t0 + i);
        $display("%s write %0d: addr=%0d tile=%0d row=%0d cycle=%0d", tag, i,
                 w_addr[base+i], tbl[first+i].tile, tbl[first+i].row, w_cyc[base+i]);
      end
    end
  endtask

  initial begin
    int a2 [16] = '{0, 2, 4, 6, 1, 3, 5, 7, 8, 10, 12, 14, 9, 11, 13, 15};
    int t, dc, base, st0, dn0;

    // 0-3: 4x16 single tile; 4-19: 8x32; 20-35: 16x16 stall case;
    // 36-51: 16x16 overflow case; 52-55: restart after reset.
    for (int i = 0; i < 4; i++)  tbl[i]      = '{AW'(i), 1, i};
    for (int i = 0; i < 16; i++) tbl[4+i]    = '{AW'(a2[i]), 2 + i / 4, i % 4};
    for (int i = 0; i < 16; i++) tbl[20+i]   = '{AW'(i), 6 + i / 4, i % 4};
    for (int i = 0; i < 16; i++) begin
      int ids [4] = '{10, 11, 14, 15};
      tbl[36+i] = '{AW'(i), ids[i/4], i % 4};
    end
    for (int i = 0; i < 4; i++)  tbl[52+i]   = '{AW'(i), 31, i};

    // Reset state.
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    chk("rst_wr_en", wr_en_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_overflow", overflow_o, 1'b0);
    chk("rst_addr", wr_addr_o, 0);
    chk("rst_data", wr_data_o, 0);

    // Single 4x16 tile: writes at t+1..t+4, done at t+5, port holds after.
    base = w_addr.size();
    do_start(4, 16);
    chk("t1_busy", busy_o, 1'b1);
    t = cyc + 1;
    push(1);
    wait_done(40, dc);
    chk("t1_done_cycle", dc, t + 5);
    verify_tbl("t1", base, 0, 4, t + 1);
    tick();
    chk("t1_idle_busy", busy_o, 1'b0);
    chk("t1_hold_en", wr_en_o, 1'b0);
    chk("t1_hold_addr", wr_addr_o, 3);
    chk("t1_hold_data", wr_data_o, make_row(1, 3));

    // 8x32: tiles every 4 cycles, no gaps, never stalls, stray start ignored.
    base = w_addr.size();
    st0  = stall_cnt;
    do_start(8, 32);
    t = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      push(2 + k);
      if (k == 1) begin
        M_size_i = AW'(4);
        N_size_i = AW'(16);
        start_i  = 1'b1;
      end
      tick();
      start_i = 1'b0;
      tick();
      tick();
    end
    wait_done(40, dc);
    chk("t2_done_cycle", dc, t + 17);
    verify_tbl("t2", base, 4, 16, t + 1);
    chk("t2_stall_seen", stall_cnt - st0, 0);
    tick();

    // 16x16: two tiles back to back fill the FIFO; third only with a pop.
    base = w_addr.size();
    do_start(16, 16);
    t = cyc + 1;
    push(6);
    chk("t3_stall_after1", stall_o, 1'b0);
    push(7);
    chk("t3_stall_after2", stall_o, 1'b1);
    tick();
    tick();
    chk("t3_stall_before3", stall_o, 1'b1);
    push(8);
    chk("t3_stall_after3", stall_o, 1'b1);
    chk("t3_overflow_after3", overflow_o, 1'b0);
    wait_no_stall(20);
    push(9);
    wait_done(40, dc);
    chk("t3_done_cycle", dc, t + 17);
    chk("t3_overflow", overflow_o, 1'b0);
    verify_tbl("t3", base, 20, 16, t + 1);
    tick();

    // Four consecutive pushes into an empty FIFO: the head cannot pop until
    // its fourth row, so pushes three and four both meet a full FIFO.
    base = w_addr.size();
    do_start(16, 16);
    t = cyc + 1;
    push(10);
    push(11);
    chk("t4_overflow_after2", overflow_o, 1'b0);
    push(12);
    chk("t4_overflow_after3", overflow_o, 1'b1);
    push(13);
    chk("t4_overflow_after4", overflow_o, 1'b1);
    wait_no_stall(20);
    push(14);
    wait_no_stall(20);
    push(15);
    wait_done(40, dc);
    chk("t4_done_cycle", dc, t + 17);
    verify_tbl("t4", base, 36, 16, t + 1);
    tick();
    chk("t4_overflow_idle", overflow_o, 1'b1);

    // Empty job (M/TileM = 0): done next cycle, no writes, overflow cleared.
    base = w_addr.size();
    do_start(2, 16);
    chk("t5_done", done_o, 1'b1);
    chk("t5_busy", busy_o, 1'b1);
    chk("t5_overflow_cleared", overflow_o, 1'b0);
    tick();
    chk("t5_done_gone", done_o, 1'b0);
    chk("t5_busy_gone", busy_o, 1'b0);
    chk("t5_writes", w_addr.size() - base, 0);

    // Reset while row 2 is on the write port, then a fresh job.
    base = w_addr.size();
    do_start(4, 16);
    t = cyc + 1;
    push(30);
    tick();
    tick();
    tick();
    chk("t6_row2_en", wr_en_o, 1'b1);
    chk("t6_row2_addr", wr_addr_o, 2);
    rst_i = 1'b1;
    dn0 = done_cnt;
    tick();
    chk("t6_rst_en", wr_en_o, 1'b0);
    chk("t6_rst_busy", busy_o, 1'b0);
    rst_i = 1'b0;
    repeat (6) tick();
    chk("t6_no_done", done_cnt - dn0, 0);
    chk("t6_writes", w_addr.size() - base, 3);
    base = w_addr.size();
    do_start(4, 16);
    t = cyc + 1;
    push(31);
    wait_done(40, dc);
    chk("t6_done_cycle", dc, t + 5);
    verify_tbl("t6", base, 52, 4, t + 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
